// File: rtl/dst_hs_resp_if.sv
// dst_hs_resp_if: 4-phase source handshake plus local valid/ready consumer port
interface dst_hs_resp_if #(parameter int DW = 32);
  logic          SRC_REQ;
  logic [DW-1:0] SRC_DATA;
  logic          DST_ACK;
  logic          DST_VALID;
  logic          DST_READY;
  logic [DW-1:0] DST_DATA;
  logic          DST_ERR;
  logic [15:0]   DST_XFER_CNT;
  modport master (
    output SRC_REQ, SRC_DATA, DST_READY,
    input  DST_ACK, DST_VALID, DST_DATA, DST_ERR, DST_XFER_CNT
  );
  modport slave (
    input  SRC_REQ, SRC_DATA, DST_READY,
    output DST_ACK, DST_VALID, DST_DATA, DST_ERR, DST_XFER_CNT
  );
endinterface

// File: rtl/dst_hs_resp.sv
// dst_hs_resp: destination side of a 4-phase CDC handshake, presenting each captured word on a valid/ready port
module dst_hs_resp #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 3
) (
  input logic         DST_CLK,
  input logic         DST_CLRN,
  dst_hs_resp_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1, ACK = 2'd2} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [DW-1:0]          data_q, data_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   req_s;
  // SRC_DATA is only sampled once req_s proves the source is holding it stable
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.SRC_REQ};
  assign req_s  = sync_q[SYNC_STAGES-1];
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        valid_d = req_s;
        ack_d   = 1'b0;
        data_d  = req_s ? bus.SRC_DATA : data_q;
        state_d = req_s ? VALID : IDLE;
      end
      VALID: begin
        // a withdrawn request wins over a simultaneous consumer accept
        if (!req_s) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (bus.DST_READY) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = req_s;
        state_d = req_s ? ACK : IDLE;
      end
      default: begin
        valid_d = 1'b0;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge DST_CLK) begin
    if (!DST_CLRN) begin
      state_q <= IDLE;
      sync_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.DST_ACK      = ack_q;
  assign bus.DST_VALID    = valid_q;
  assign bus.DST_DATA     = data_q;
  assign bus.DST_ERR      = err_q;
  assign bus.DST_XFER_CNT = cnt_q;
endmodule

// File: tb/tb_dst_hs_resp.sv
// tb_dst_hs_resp: directed stimulus with a data scoreboard checked by an independent monitor
module tb_dst_hs_resp;
  logic DST_CLK = 1'b0;
  logic DST_CLRN = 1'b0;
  dst_hs_resp_if #(.DW(32)) bus ();
  dst_hs_resp_if #(.DW(32)) if2 ();
  dst_hs_resp_if #(.DW(32)) if4 ();
  dst_hs_resp #(.DW(32), .SYNC_STAGES(3)) dut  (.DST_CLK(DST_CLK), .DST_CLRN(DST_CLRN), .bus(bus));
  dst_hs_resp #(.DW(32), .SYNC_STAGES(2)) dut2 (.DST_CLK(DST_CLK), .DST_CLRN(DST_CLRN), .bus(if2));
  dst_hs_resp #(.DW(32), .SYNC_STAGES(4)) dut4 (.DST_CLK(DST_CLK), .DST_CLRN(DST_CLRN), .bus(if4));
  assign if2.SRC_REQ   = bus.SRC_REQ;
  assign if2.SRC_DATA  = bus.SRC_DATA;
  assign if2.DST_READY = bus.DST_READY;
  assign if4.SRC_REQ   = bus.SRC_REQ;
  assign if4.SRC_DATA  = bus.SRC_DATA;
  assign if4.DST_READY = bus.DST_READY;
  always #5 DST_CLK = ~DST_CLK;
  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_cnt = 16'd0;
  logic seen_ack;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge DST_CLK);
    #1;
  endtask
  task automatic wait_ack(input logic v, input string n);
    for (int k = 0; k < 40 && bus.DST_ACK !== v; k++) step();
    chk(n, {31'd0, bus.DST_ACK}, {31'd0, v});
  endtask
  task automatic xfer(input logic [31:0] d);
    bus.SRC_DATA = d;
    sb.push_back(d);
    bus.SRC_REQ = 1'b1;
    wait_ack(1'b1, "xfer_ack_rise");
    bus.SRC_REQ = 1'b0;
    wait_ack(1'b0, "xfer_ack_fall");
    exp_cnt++;
  endtask
  // every accepted word must match the oldest outstanding expectation
  always @(negedge DST_CLK) begin
    if (DST_CLRN && bus.DST_VALID && bus.DST_READY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got %h expected no word", bus.DST_DATA);
      end else chk("sb_data", bus.DST_DATA, sb.pop_front());
    end
  end
  initial begin
    bus.SRC_REQ = 1'b0;
    bus.SRC_DATA = '0;
    bus.DST_READY = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, bus.DST_VALID}, 0);
    chk("rst_ack", {31'd0, bus.DST_ACK}, 0);
    chk("rst_data", bus.DST_DATA, 0);
    chk("rst_err", {31'd0, bus.DST_ERR}, 0);
    chk("rst_cnt", {16'd0, bus.DST_XFER_CNT}, 0);
    DST_CLRN = 1'b1;
    bus.SRC_DATA = 32'h1234_5678;
    bus.SRC_REQ = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("lat_s2", {31'd0, if2.DST_VALID}, {31'd0, e >= 3});
      chk("lat_s3", {31'd0, bus.DST_VALID}, {31'd0, e >= 4});
      chk("lat_s4", {31'd0, if4.DST_VALID}, {31'd0, e >= 5});
    end
    chk("data_s2", if2.DST_DATA, 32'h1234_5678);
    chk("data_s3", bus.DST_DATA, 32'h1234_5678);
    chk("data_s4", if4.DST_DATA, 32'h1234_5678);
    bus.SRC_REQ = 1'b0;
    DST_CLRN = 1'b0;
    step();
    DST_CLRN = 1'b1;
    bus.DST_READY = 1'b1;
    bus.SRC_DATA = 32'hA5A5_0001;
    sb.push_back(32'hA5A5_0001);
    bus.SRC_REQ = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("basic_valid", {31'd0, bus.DST_VALID}, {31'd0, e == 4});
      chk("basic_ack", {31'd0, bus.DST_ACK}, {31'd0, e == 5});
    end
    bus.SRC_REQ = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("basic_ack_fall", {31'd0, bus.DST_ACK}, {31'd0, e < 4});
    end
    exp_cnt = 16'd1;
    chk("basic_cnt", {16'd0, bus.DST_XFER_CNT}, {16'd0, exp_cnt});
    bus.DST_READY = 1'b0;
    bus.SRC_DATA = 32'hB0B0_0002;
    sb.push_back(32'hB0B0_0002);
    bus.SRC_REQ = 1'b1;
    repeat (4) step();
    chk("bp_valid_rise", {31'd0, bus.DST_VALID}, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", {31'd0, bus.DST_VALID}, 1);
      chk("bp_data", bus.DST_DATA, 32'hB0B0_0002);
      chk("bp_ack", {31'd0, bus.DST_ACK}, 0);
    end
    bus.DST_READY = 1'b1;
    step();
    chk("bp_ack_rise", {31'd0, bus.DST_ACK}, 1);
    bus.SRC_REQ = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    exp_cnt++;
    chk("bp_cnt", {16'd0, bus.DST_XFER_CNT}, {16'd0, exp_cnt});
    bus.DST_READY = 1'b0;
    bus.SRC_DATA = 32'hC0C0_0003;
    bus.SRC_REQ = 1'b1;
    repeat (4) step();
    chk("wd_valid_rise", {31'd0, bus.DST_VALID}, 1);
    bus.SRC_REQ = 1'b0;
    seen_ack = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      seen_ack |= bus.DST_ACK;
      chk("wd_valid", {31'd0, bus.DST_VALID}, {31'd0, e < 4});
      chk("wd_err", {31'd0, bus.DST_ERR}, {31'd0, e == 4});
    end
    repeat (3) begin
      step();
      seen_ack |= bus.DST_ACK;
    end
    chk("wd_no_ack", {31'd0, seen_ack}, 0);
    chk("wd_cnt", {16'd0, bus.DST_XFER_CNT}, {16'd0, exp_cnt});
    bus.DST_READY = 1'b1;
    force dut.cnt_d = 16'hFFFF;
    step();
    release dut.cnt_d;
    step();
    chk("wrap_preload", {16'd0, bus.DST_XFER_CNT}, 32'h0000_FFFF);
    exp_cnt = 16'hFFFF;
    xfer(32'hD0D0_0004);
    chk("wrap_cnt", {16'd0, bus.DST_XFER_CNT}, {16'd0, exp_cnt});
    chk("err_sticky", {31'd0, bus.DST_ERR}, 1);
    for (int i = 0; i < 100; i++) xfer($urandom);
    step();
    chk("rand_cnt", {16'd0, bus.DST_XFER_CNT}, {16'd0, exp_cnt});
    chk("rand_sb_drained", sb.size(), 0);
    bus.DST_READY = 1'b0;
    bus.SRC_DATA = 32'hE0E0_0005;
    sb.push_back(32'hE0E0_0005);
    bus.SRC_REQ = 1'b1;
    repeat (4) step();
    chk("rv_valid_rise", {31'd0, bus.DST_VALID}, 1);
    DST_CLRN = 1'b0;
    step();
    chk("rv_valid", {31'd0, bus.DST_VALID}, 0);
    chk("rv_ack", {31'd0, bus.DST_ACK}, 0);
    chk("rv_data", bus.DST_DATA, 0);
    chk("rv_err", {31'd0, bus.DST_ERR}, 0);
    chk("rv_cnt", {16'd0, bus.DST_XFER_CNT}, 0);
    DST_CLRN = 1'b1;
    exp_cnt = 16'd0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("rv_relat", {31'd0, bus.DST_VALID}, {31'd0, e == 4});
    end
    chk("rv_redata", bus.DST_DATA, 32'hE0E0_0005);
    bus.DST_READY = 1'b1;
    step();
    chk("rv_ack_rise", {31'd0, bus.DST_ACK}, 1);
    bus.SRC_REQ = 1'b0;
    wait_ack(1'b0, "rv_ack_fall");
    exp_cnt++;
    chk("rv_cnt_final", {16'd0, bus.DST_XFER_CNT}, {16'd0, exp_cnt});
    chk("final_sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dst_hs_resp.md
DST_HS_RESP -- requirements
Module: dst_hs_resp

Interface
REQ-001 The block SHALL have parameter DW, default 32: width of the transferred data word.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 3: flops in the SRC_REQ synchronizer (legal 2..4).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 DST_CLK  in  1  destination clock; all flops clock on its rising edge.
REQ-005 DST_CLRN  in  1  synchronous active-low reset.
REQ-006 SRC_REQ  in  1  4-phase request; asynchronous; driven by a source-domain flop.
REQ-007 SRC_DATA  in  DW  source data; held stable by the source while SRC_REQ=1.
REQ-008 DST_ACK  out  1  4-phase acknowledge to the source; driven directly by a flop.
REQ-009 DST_VALID  out  1  captured word available to the local consumer.
REQ-010 DST_READY  in  1  local consumer accepts the word.
REQ-011 DST_DATA  out  DW  captured word; registered.
REQ-012 DST_ERR  out  1  sticky protocol-error flag.
REQ-013 DST_XFER_CNT  out  16  count of completed transfers; registered.

Function
REQ-014 SRC_REQ SHALL pass through a chain of SYNC_STAGES flops; req_s is the last stage, and no other logic SHALL sample SRC_REQ.
REQ-015 SRC_DATA SHALL be sampled only on the IDLE->VALID transition; it SHALL never pass through the synchronizer.
REQ-016 The FSM SHALL have the states IDLE, VALID and ACK.
REQ-017 IDLE: DST_VALID=0 and DST_ACK=0. If req_s=1: DST_DATA<=SRC_DATA, DST_VALID<=1, next state VALID.
REQ-018 VALID: DST_VALID=1 and DST_DATA is held constant.
REQ-019 VALID, when DST_READY=1 and req_s=1: DST_VALID<=0, DST_ACK<=1, DST_XFER_CNT<=DST_XFER_CNT+1, next state ACK.
REQ-020 VALID, when req_s=0 (source withdrew): DST_ERR<=1, DST_VALID<=0, DST_ACK stays 0, counter unchanged, next state IDLE. This case takes priority over DST_READY.
REQ-021 ACK: DST_ACK=1 until req_s=0 is seen, then DST_ACK<=0 and next state IDLE.
REQ-022 ACK: a word SHALL NOT be captured or presented while in ACK.
REQ-023 Latency: SRC_REQ rising, meeting setup before edge E1, SHALL make DST_VALID=1 after edge E(SYNC_STAGES+1), i.e. 4 edges for the default.
REQ-024 DST_ACK SHALL rise on the edge that samples DST_VALID=1 and DST_READY=1.
REQ-025 SRC_REQ falling SHALL make DST_ACK=0 after SYNC_STAGES+1 edges.
REQ-026 DST_READY=1 while DST_VALID=0 SHALL have no effect.
REQ-027 DST_READY=1 on the first VALID cycle SHALL complete the transfer, giving a minimum VALID pulse of 1 cycle.
REQ-028 DST_XFER_CNT SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-029 DST_ERR SHALL clear only on reset.
REQ-030 Minimum round trip: back-to-back transfers SHALL NOT start a new capture until the edge after the IDLE return.
REQ-031 Illegal state encodings SHALL decode to IDLE on the next edge, with outputs as for IDLE.

Reset
REQ-032 When DST_CLRN=0 at a rising edge, all flops SHALL clear on that edge: sync chain 0, state IDLE, DST_VALID=0, DST_ACK=0, DST_DATA=0, DST_ERR=0, DST_XFER_CNT=0.
REQ-033 Reset mid-transfer SHALL abandon the word with no ACK.
REQ-034 If SRC_REQ is still 1 after reset release, the word SHALL be re-captured and re-delivered as a new transfer (REQ-023 timing).
REQ-035 DST_CLRN SHALL NOT be synchronized inside the block.

Verification
REQ-036 Basic transfer: SRC_DATA=0xA5A5_0001, SRC_REQ rises, DST_READY=1 -> DST_VALID on edge 4, DST_DATA=0xA5A5_0001, DST_ACK on edge 5, drop SRC_REQ -> DST_ACK=0 4 edges later, DST_XFER_CNT=1.
REQ-037 Backpressure: DST_READY=0 for 10 cycles -> DST_VALID and DST_DATA stay stable and DST_ACK=0 throughout; DST_READY=1 -> DST_ACK=1 next edge.
REQ-038 Withdrawal: SRC_REQ drops during VALID with DST_READY=0 -> DST_ERR=1 sticky, DST_VALID=0, DST_ACK never 1, DST_XFER_CNT unchanged.
REQ-039 Wrap: preload the count to 0xFFFF via 65535 transfers (or force) then one transfer -> DST_XFER_CNT=0x0000; 100 random back-to-back transfers -> data order and values match exactly.
REQ-040 Reset mid-VALID with SRC_REQ held 1: assert DST_CLRN=0 for 1 edge -> all outputs 0; after release DST_VALID re-asserts 4 edges later with the same data.
REQ-041 Sync-stage sweep: SYNC_STAGES=2 and SYNC_STAGES=4 -> DST_VALID at edge 3 and edge 5 respectively, all other checks unchanged.
